// File: rtl/arbiter_out.sv
// arbiter_out: round-robin output-port arbiter with wormhole packet lock and credit flow control
module arbiter_out #(
   parameter int CRED_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_n_i,
   input  logic       req_s_i,
   input  logic       req_e_i,
   input  logic       req_w_i,
   input  logic       req_l_i,
   input  logic       last_n_i,
   input  logic       last_s_i,
   input  logic       last_e_i,
   input  logic       last_w_i,
   input  logic       last_l_i,
   input  logic       credit_i,
   output logic       pop_req_n_o,
   output logic       pop_req_s_o,
   output logic       pop_req_e_o,
   output logic       pop_req_w_o,
   output logic       pop_req_l_o,
   output logic [2:0] sel_o,
   output logic       valid_o,
   output logic [2:0] credit_cnt_o,
   output logic       busy_o
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;
   localparam logic [2:0] CM     = 3'(CRED_MAX);
   logic [0:0] state;
   logic [2:0] owner, ptr, cnt, win, gidx;
   logic [3:0] s;
   logic [4:0] req, last, pop;
   logic       any, gnt;
   assign req  = {req_l_i, req_w_i, req_e_i, req_s_i, req_n_i};
   assign last = {last_l_i, last_w_i, last_e_i, last_s_i, last_n_i};
   // descending scan so the requester closest after ptr wins
   always_comb begin
      win = 3'd0;
      any = 1'b0;
      s   = 4'd0;
      for (int i = 4; i >= 0; i--) begin
         s = 4'(ptr) + 4'(i + 1);
         s = (s >= 4'd5) ? s - 4'd5 : s;
         if (req[s[2:0]]) begin
            win = s[2:0];
            any = 1'b1;
         end
      end
   end
   always_comb begin
      gidx  = (state == LOCKED) ? owner : win;
      gnt   = rst && (cnt != 3'd0) && ((state == LOCKED) ? req[owner] : any);
      pop   = gnt ? (5'b00001 << gidx) : 5'b00000;
      sel_o = (rst && (gnt || state == LOCKED)) ? gidx : 3'd0;
   end
   assign {pop_req_l_o, pop_req_w_o, pop_req_e_o, pop_req_s_o, pop_req_n_o} = pop;
   assign valid_o      = gnt;
   assign busy_o       = rst && (state == LOCKED);
   assign credit_cnt_o = rst ? cnt : CM;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         owner <= 3'd0;
         ptr   <= 3'd4;
         cnt   <= CM;
      end else begin
         if (gnt && !credit_i)
            cnt <= cnt - 3'd1;
         else if (!gnt && credit_i && cnt != CM)
            cnt <= cnt + 3'd1;
         if (gnt && last[gidx]) begin
            state <= IDLE;
            ptr   <= gidx;
         end else if (gnt && state == IDLE) begin
            state <= LOCKED;
            owner <= gidx;
         end
      end
   end
endmodule
